oled_spi_receiver: RTL and testbench
====================================

// Module: oled_spi_receiver
// PURPOSE
//  Receives the PmodOLEDrgb (SSD1331-style) serial stream produced by our Oled_Display driver and decodes it.
//  Inputs are the cs/sdin/sclk/d_cn pins.
//  Outputs are command bytes and addressed RGB565 pixel writes.
//  Used as a synthesizable display sink for loopback checking on the board and as the scoreboard front end in sims.
//  All inputs are oversampled in the single clk domain.
// PARAMETERS
//  WIDTH        96  display columns (x range 0..WIDTH-1)
//  HEIGHT       64  display rows (y range 0..HEIGHT-1)
//  SYNC_STAGES  2   synchroniser flops on each serial input (>=2)
// PORTS
//  clk          in   1   system clock (100 MHz); SPI sclk must stay high >=3 and low >=3 clk cycles
//  reset_n      in   1   asynchronous, active-low reset
//  cs           in   1   chip select, active low
//  sdin         in   1   serial data, MSB first, sampled on sclk rising edge
//  sclk         in   1   serial clock
//  d_cn         in   1   1 = data (pixel) byte, 0 = command byte; sampled with bit 0 of each byte
//  cmd_valid    out  1   1-cycle pulse: cmd_byte holds a received command-mode byte
//  cmd_byte     out  8   last command-mode byte
//  pix_valid    out  1   1-cycle pulse: pixel write on pix_x/pix_y/pix_data
//  pix_x        out  7   column of the pixel write
//  pix_y        out  6   row of the pixel write
//  pixel_index  out  13  pix_y*WIDTH + pix_x; same index map as Oled_Display
//  pix_data     out  16  RGB565 pixel (first data byte = [15:8])
//  frame_done   out  1   1-cycle pulse, coincident with pix_valid, on the last pixel of the window
// BEHAVIOUR
//  Reset: all outputs 0. Bit count 0, pending high byte cleared, parser state = OP.
//    Window reset to col 0..WIDTH-1, row 0..HEIGHT-1. Cursor reset to (0,0).
//  Input path: cs, sdin, sclk and d_cn each pass through SYNC_STAGES flops.
//    Rising edge of the synced sclk with synced cs=0 shifts synced sdin into an 8-bit shift register.
//  Byte completion: on the 8th edge, the byte and d_cn go to the decoder. Bit count returns to 0.
//    Output pulses appear exactly SYNC_STAGES+2 clk cycles after the 8th sclk rise at the pin.
//  cs deassertion (synced cs=1) clears the bit count and discards any partial byte.
//    The pending pixel high byte, the parser state and the cursor are kept.
//  Command bytes (d_cn=0): every one pulses cmd_valid, including argument bytes. Parser FSM:
//    OP: 0x15 -> COL_S; 0x75 -> ROW_S; any other byte -> OP.
//    COL_S -> COL_E -> OP. Capture col_start, then col_end.
//      On COL_E, x cursor is set to col_start.
//    ROW_S -> ROW_E -> OP. Capture row_start, then row_end.
//      On ROW_E, y cursor is set to row_start.
//    Args are clamped: col > WIDTH-1 -> WIDTH-1; row > HEIGHT-1 -> HEIGHT-1. If end < start, end = start.
//    A data byte arriving in COL_S/COL_E/ROW_S/ROW_E aborts: state -> OP, partial args discarded.
//  Data bytes (d_cn=1): the first byte is held as the high byte; the second completes the pixel.
//    pix_valid pulses with the current cursor, then the cursor advances:
//      x==col_end -> x=col_start and y advances, else x+1.
//      y advance: y==row_end -> y=row_start and frame_done pulses with this pixel, else y+1.
//  A command byte between the two data bytes does not clear the pending high byte.
//  pix_x, pix_y, pixel_index, pix_data and cmd_byte hold their values between pulses.
//  cmd_valid and pix_valid never pulse in the same cycle (one byte per completion).
// TESTING
//  1. Assert reset_n=0 mid-stream -> all outputs 0 immediately; after release, a pixel F8,00 -> (0,0), data 0xF800.
//  2. Send cmd 0xAF -> single cmd_valid, cmd_byte=0xAF, SYNC_STAGES+2 cycles after the 8th sclk rise; no pix_valid.
//  3. Send cmds 15,10,11,75,05,05, then data F8,00,07,E0,00,1F,FF,FF.
//     -> pixels (16,5)=F800, (17,5)=07E0 with frame_done, (16,5)=001F, (17,5)=FFFF with frame_done.
//  4. Send 6144 pixels in the default window -> last is (95,63), pixel_index 6143, single frame_done; next pixel is (0,0).
//  5. Raise cs after 5 bits, then send cmd 0x3C -> no output from the partial byte; cmd_byte=0x3C.
//  6. Send 15,70,7F -> window col 95..95; then 2 pixels -> both x=95, y=0 then y=1.
//  7. Send 15, then data 12 -> parser aborts to OP.
//     Next data 34 completes pixel 0x1234 at the unchanged cursor; next cmd 15 re-enters COL_S.

Source files
------------

// File: rtl/oled_spi_receiver_if.sv
// Pin-level and decoded-output bundle of the PmodOLEDrgb serial sink.
// cmd_valid/pix_valid are single-cycle strobes with no ready: the serial stream cannot stall, so the sink takes every pulse; data fields hold between strobes.
interface oled_spi_receiver_if;
    logic        cs;
    logic        sdin;
    logic        sclk;
    logic        d_cn;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pix_valid;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
    logic [12:0] pixel_index;
    logic [15:0] pix_data;
    logic        frame_done;
    logic [2:0]  parser_state;

    modport master (
        output cs, sdin, sclk, d_cn,
        input  cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pixel_index,
               pix_data, frame_done, parser_state
    );

    modport slave (
        input  cs, sdin, sclk, d_cn,
        output cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pixel_index,
               pix_data, frame_done, parser_state
    );
endinterface

// File: rtl/oled_spi_receiver.sv
// Oversampling SSD1331-style serial sink: rebuilds bytes from cs/sdin/sclk/d_cn,
// reports command bytes and turns data byte pairs into addressed RGB565 pixel writes.
module oled_spi_receiver #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    oled_spi_receiver_if.slave bus
);
    typedef enum logic [2:0] {
        ST_OP    = 3'd0,
        ST_COL_S = 3'd1,
        ST_COL_E = 3'd2,
        ST_ROW_S = 3'd3,
        ST_ROW_E = 3'd4
    } state_t;

    localparam logic [7:0]  COL_MAX   = 8'(WIDTH - 1);
    localparam logic [7:0]  ROW_MAX   = 8'(HEIGHT - 1);
    localparam logic [12:0] ROW_PITCH = 13'(WIDTH);

    logic [SYNC_STAGES-1:0] cs_sync, sdin_sync, sclk_sync, dcn_sync;
    logic                   sclk_prev;
    logic                   cs_s, sdin_s, sclk_s, dcn_s, sclk_rise;

    // cs idles high so a reset never looks like a selected bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '1;
            sdin_sync <= '0;
            sclk_sync <= '0;
            dcn_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], bus.sdin};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            dcn_sync  <= {dcn_sync[SYNC_STAGES-2:0], bus.d_cn};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign dcn_s     = dcn_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_v;
    logic       byte_dc;
    logic [7:0] byte_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            byte_v    <= 1'b0;
            byte_dc   <= 1'b0;
            byte_data <= 8'd0;
        end else begin
            byte_v <= 1'b0;
            if (cs_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], sdin_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_v    <= 1'b1;
                    byte_data <= {shreg, sdin_s};
                    byte_dc   <= dcn_s;
                end
            end
        end
    end

    state_t state_q, state_d;
    logic   cmd_en, data_en, ld_col_s, ld_col_e, ld_row_s, ld_row_e;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_OP;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_v) begin
            if (byte_dc) begin
                state_d = ST_OP;
            end else begin
                case (state_q)
                    ST_OP: begin
                        if (byte_data == 8'h15)      state_d = ST_COL_S;
                        else if (byte_data == 8'h75) state_d = ST_ROW_S;
                        else                         state_d = ST_OP;
                    end
                    ST_COL_S: state_d = ST_COL_E;
                    ST_ROW_S: state_d = ST_ROW_E;
                    default:  state_d = ST_OP;
                endcase
            end
        end
    end

    always_comb begin
        cmd_en   = byte_v & ~byte_dc;
        data_en  = byte_v & byte_dc;
        ld_col_s = cmd_en && (state_q == ST_COL_S);
        ld_col_e = cmd_en && (state_q == ST_COL_E);
        ld_row_s = cmd_en && (state_q == ST_ROW_S);
        ld_row_e = cmd_en && (state_q == ST_ROW_E);
    end

    logic [6:0]  col_clamped, col_arg, col_start, col_end, col_end_new, cur_x;
    logic [5:0]  row_clamped, row_arg, row_start, row_end, row_end_new, cur_y;
    logic [7:0]  hi_byte;
    logic        hi_valid;
    logic        cmd_valid_q, pix_valid_q, frame_done_q;
    logic [7:0]  cmd_byte_q;
    logic [6:0]  pix_x_q;
    logic [5:0]  pix_y_q;
    logic [12:0] pixel_index_q;
    logic [15:0] pix_data_q;

    // Arguments saturate to the panel edge; an end below its start collapses to the start
    always_comb begin
        col_clamped = (byte_data > COL_MAX) ? COL_MAX[6:0] : byte_data[6:0];
        row_clamped = (byte_data > ROW_MAX) ? ROW_MAX[5:0] : byte_data[5:0];
        col_end_new = (col_clamped < col_arg) ? col_arg : col_clamped;
        row_end_new = (row_clamped < row_arg) ? row_arg : row_clamped;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_arg       <= 7'd0;
            row_arg       <= 6'd0;
            col_start     <= 7'd0;
            col_end       <= COL_MAX[6:0];
            row_start     <= 6'd0;
            row_end       <= ROW_MAX[5:0];
            cur_x         <= 7'd0;
            cur_y         <= 6'd0;
            hi_byte       <= 8'd0;
            hi_valid      <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_byte_q    <= 8'd0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 7'd0;
            pix_y_q       <= 6'd0;
            pixel_index_q <= 13'd0;
            pix_data_q    <= 16'd0;
            frame_done_q  <= 1'b0;
        end else begin
            cmd_valid_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (cmd_en) begin
                cmd_valid_q <= 1'b1;
                cmd_byte_q  <= byte_data;
            end
            if (ld_col_s) col_arg <= col_clamped;
            if (ld_row_s) row_arg <= row_clamped;
            if (ld_col_e) begin
                col_start <= col_arg;
                col_end   <= col_end_new;
                cur_x     <= col_arg;
            end
            if (ld_row_e) begin
                row_start <= row_arg;
                row_end   <= row_end_new;
                cur_y     <= row_arg;
            end
            if (data_en) begin
                if (!hi_valid) begin
                    hi_byte  <= byte_data;
                    hi_valid <= 1'b1;
                end else begin
                    hi_valid      <= 1'b0;
                    pix_valid_q   <= 1'b1;
                    pix_x_q       <= cur_x;
                    pix_y_q       <= cur_y;
                    pixel_index_q <= 13'(cur_y) * ROW_PITCH + 13'(cur_x);
                    pix_data_q    <= {hi_byte, byte_data};
                    if (cur_x == col_end) begin
                        cur_x <= col_start;
                        if (cur_y == row_end) begin
                            cur_y        <= row_start;
                            frame_done_q <= 1'b1;
                        end else begin
                            cur_y <= cur_y + 6'd1;
                        end
                    end else begin
                        cur_x <= cur_x + 7'd1;
                    end
                end
            end
        end
    end

    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_byte     = cmd_byte_q;
    assign bus.pix_valid    = pix_valid_q;
    assign bus.pix_x        = pix_x_q;
    assign bus.pix_y        = pix_y_q;
    assign bus.pixel_index  = pixel_index_q;
    assign bus.pix_data     = pix_data_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.parser_state = state_q;
endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: serial driver tasks, expected-event queue, decoupled output monitor.
// The panel is instantiated 6 rows tall so a whole-frame sweep stays short.
module tb_oled_spi_receiver;
    localparam int SYNC = 2;
    localparam int PW   = 96;
    localparam int PH   = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    oled_spi_receiver_if bus();

    oled_spi_receiver #(.WIDTH(PW), .HEIGHT(PH), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Event word: {is_cmd, frame_done, x, y, index, data}
    logic [43:0] exp_q[$];
    logic [43:0] mon_act, mon_exp;
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] b);
        exp_q.push_back({1'b1, 1'b0, 7'd0, 6'd0, 13'd0, 8'd0, b});
    endtask

    task automatic push_pix(input int x, input int y, input logic [15:0] d, input logic fd);
        logic [12:0] idx;
        idx = 13'(y * PW + x);
        exp_q.push_back({1'b0, fd, 7'(x), 6'(y), idx, d});
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.sdin = b;
        repeat (2) @(negedge clk);
        bus.sclk = 1'b1;
        repeat (3) @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        if (bus.cs) begin
            @(negedge clk);
            bus.cs = 1'b0;
        end
        bus.d_cn = dc;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic cmd(input logic [7:0] b);
        push_cmd(b);
        send_byte(b, 1'b0);
    endtask

    task automatic pixel(input int x, input int y, input logic [15:0] d, input logic fd);
        push_pix(x, y, d, fd);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.frame_done) check("fd_with_pix", bus.pix_valid, 1);
            if (bus.cmd_valid || bus.pix_valid) begin
                check("cmd_pix_exclusive", bus.cmd_valid & bus.pix_valid, 0);
                if (bus.cmd_valid)
                    mon_act = {1'b1, 1'b0, 7'd0, 6'd0, 13'd0, 8'd0, bus.cmd_byte};
                else
                    mon_act = {1'b0, bus.frame_done, bus.pix_x, bus.pix_y,
                               bus.pixel_index, bus.pix_data};
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h want none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_event", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int lat;
        bus.cs   = 1'b1;
        bus.sdin = 1'b0;
        bus.sclk = 1'b0;
        bus.d_cn = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs", {bus.cmd_valid, bus.cmd_byte, bus.pix_valid, bus.pix_x, bus.pix_y,
                             bus.pixel_index, bus.pix_data, bus.frame_done}, 0);
        check("reset_state", bus.parser_state, 0);

        // Reset mid-stream: moved cursor, pending high byte and partial byte all vanish
        cmd(8'h75); cmd(8'h02); cmd(8'h03);
        send_byte(8'hF8, 1'b1);
        bus.d_cn = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        drain("drain_pre_reset");
        check("pre_reset_cmd_byte", bus.cmd_byte, 8'h03);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", {bus.cmd_valid, bus.cmd_byte, bus.pix_valid, bus.pix_x, bus.pix_y,
                                   bus.pixel_index, bus.pix_data, bus.frame_done}, 0);
        check("async_reset_state", bus.parser_state, 0);
        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        pixel(0, 0, 16'hF800, 1'b0);
        drain("drain_t1");

        // Command latency measured from the 8th sclk rise at the pin
        b = 8'hAF;
        push_cmd(b);
        bus.d_cn = 1'b0;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        @(negedge clk);
        bus.sdin = b[0];
        repeat (2) @(negedge clk);
        bus.sclk = 1'b1;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (bus.cmd_valid) break;
        end
        check("cmd_latency", lat, SYNC + 2);
        repeat (3) @(negedge clk);
        bus.sclk = 1'b0;
        drain("drain_t2");

        // Whole frame in the full window (set with out-of-range args)
        cmd(8'h15); cmd(8'h00); cmd(8'hFF);
        cmd(8'h75); cmd(8'h00); cmd(8'hFF);
        for (int y = 0; y < PH; y++)
            for (int x = 0; x < PW; x++)
                pixel(x, y, 16'(y * PW + x) ^ 16'h5A3C, (x == PW - 1) && (y == PH - 1));
        pixel(0, 0, 16'h0F0F, 1'b0);
        drain("drain_frame");

        // Two-column, one-row window
        cmd(8'h15); cmd(8'h10); cmd(8'h11);
        cmd(8'h75); cmd(8'h05); cmd(8'h05);
        pixel(16, 5, 16'hF800, 1'b0);
        pixel(17, 5, 16'h07E0, 1'b1);
        pixel(16, 5, 16'h001F, 1'b0);
        pixel(17, 5, 16'hFFFF, 1'b1);
        drain("drain_t3");

        // Partial byte dropped on cs release
        bus.d_cn = 1'b0;
        @(negedge clk);
        bus.cs = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        @(negedge clk);
        bus.cs = 1'b1;
        repeat (4) @(negedge clk);
        cmd(8'h3C);
        drain("drain_t5");
        check("cmd_byte_hold", bus.cmd_byte, 8'h3C);

        // Single-column window at the right edge, then end < start on rows
        cmd(8'h75); cmd(8'h00); cmd(8'h05);
        cmd(8'h15); cmd(8'h70); cmd(8'h7F);
        pixel(95, 0, 16'h1111, 1'b0);
        pixel(95, 1, 16'h2222, 1'b0);
        cmd(8'h75); cmd(8'h04); cmd(8'h01);
        pixel(95, 4, 16'h3333, 1'b1);
        drain("drain_t6");

        // Data byte aborts an argument sequence; high byte survives a command
        cmd(8'h15);
        send_byte(8'h12, 1'b1);
        repeat (6) @(negedge clk);
        check("abort_to_op", bus.parser_state, 0);
        push_pix(95, 4, 16'h1234, 1'b1);
        send_byte(8'h34, 1'b1);
        cmd(8'h15);
        repeat (6) @(negedge clk);
        check("reenter_col_s", bus.parser_state, 1);
        cmd(8'h00); cmd(8'h5F);
        send_byte(8'hAB, 1'b1);
        cmd(8'h00);
        push_pix(0, 4, 16'hABCD, 1'b0);
        send_byte(8'hCD, 1'b1);
        drain("drain_t7");
        check("pix_data_hold", bus.pix_data, 16'hABCD);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
